pe_mac_pipe: RTL and testbench

- Parametrised behavioural successor to the fixed-latency DSP PE/muladd/mul wrappers used by the Montgomery multiplier array.
- One block covers all four operations, selected per transaction by a mode field:
  - MUL: a*b
  - MULADD: a*b + su
  - PE: a*b + m*q + su + sl
  - ACC: chained accumulate
- Adds a valid pipeline, a clock-enable stall and an internal accumulator.
- Pure RTL, no vendor IP; multiplies still infer into DSP slices.

---
 rtl/pe_mac_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_pe_mac_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_pipe.sv
// pe_mac_pipe: parametrised multiply / multiply-add / PE / accumulate pipeline.
//
// Modes (per transaction): 0=MUL a*b, 1=MULADD a*b+U, 2=PE a*b+m*q+U+L,
// 3=ACC acc+a*b+m*q, with U=(su<<SU_SH) and L=(sl<<SL_SH) truncated to SW bits.
// Results are truncated modulo 2^SW.
//
// Pipeline split by LAT:
//   LAT=1 : output register only
//   LAT=2 : operand regs -> output
//   LAT=3 : operand regs -> product regs -> output
//   LAT=4 : operand regs -> product regs -> partial-sum regs -> output
// The accumulator term is added in front of the output register so that
// back-to-back ACC transactions chain without any hazard stall.
//
// Optional feature: define PE_MAC_OVF_FLAG_EN to add out_ovf, a registered
// flag set when the full-precision sum of the emerging result is >= 2^SW.

module pe_mac_pipe #(
  parameter int unsigned AW    = 17,
  parameter int unsigned BW    = 17,
  parameter int unsigned SW    = 48,
  parameter int unsigned LAT   = 3,
  parameter int unsigned SU_SH = 17,
  parameter int unsigned SL_SH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [1:0]    in_mode,
  input  logic [AW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [AW-1:0] in_m,
  input  logic [BW-1:0] in_q,
  input  logic [SW-1:0] in_sl,
  input  logic [SW-1:0] in_su,
  output logic          out_valid,
  output logic [1:0]    out_mode,
`ifdef PE_MAC_OVF_FLAG_EN
  output logic          out_ovf,
`endif
  output logic [SW-1:0] out_s
);

  localparam logic [1:0] MODE_MUL    = 2'd0;
  localparam logic [1:0] MODE_MULADD = 2'd1;
  localparam logic [1:0] MODE_PE     = 2'd2;
  localparam logic [1:0] MODE_ACC    = 2'd3;

  // Internal sum width: two guard bits above the widest term keep the
  // full-precision sum exact when the overflow flag is needed.
`ifdef PE_MAC_OVF_FLAG_EN
  localparam int unsigned PW = AW + BW;
  localparam int unsigned FW = ((SW > PW) ? SW : PW) + 2;
`else
  localparam int unsigned FW = SW;
`endif

  if ((LAT < 1) || (LAT > 4)) begin : g_lat_check
    $error("pe_mac_pipe: LAT must be in the range 1..4");
  end

  // ---------------------------------------------------------------------
  // Stage 0: operand selection. Unused operands are forced to zero so the
  // result never depends on them.
  // ---------------------------------------------------------------------
  logic [SW-1:0] w_su_sh;
  logic [SW-1:0] w_sl_sh;
  logic [AW-1:0] w_s0_m;
  logic [BW-1:0] w_s0_q;
  logic [SW-1:0] w_s0_u;
  logic [SW-1:0] w_s0_l;

  assign w_su_sh = in_su << SU_SH;
  assign w_sl_sh = in_sl << SL_SH;

  // Gate the per-mode terms at the pipeline entry.
  always_comb begin
    w_s0_m = '0;
    w_s0_q = '0;
    w_s0_u = '0;
    w_s0_l = '0;
    unique case (in_mode)
      MODE_MUL: begin
      end
      MODE_MULADD: begin
        w_s0_u = w_su_sh;
      end
      MODE_PE: begin
        w_s0_m = in_m;
        w_s0_q = in_q;
        w_s0_u = w_su_sh;
        w_s0_l = w_sl_sh;
      end
      MODE_ACC: begin
        w_s0_m = in_m;
        w_s0_q = in_q;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 1: operand registers (LAT >= 2).
  // ---------------------------------------------------------------------
  logic          w_s1_valid;
  logic [1:0]    w_s1_mode;
  logic [AW-1:0] w_s1_a;
  logic [BW-1:0] w_s1_b;
  logic [AW-1:0] w_s1_m;
  logic [BW-1:0] w_s1_q;
  logic [SW-1:0] w_s1_u;
  logic [SW-1:0] w_s1_l;

  if (LAT >= 2) begin : g_op_reg
    logic          r_valid;
    logic [1:0]    r_mode;
    logic [AW-1:0] r_a;
    logic [BW-1:0] r_b;
    logic [AW-1:0] r_m;
    logic [BW-1:0] r_q;
    logic [SW-1:0] r_u;
    logic [SW-1:0] r_l;

    // Operand-stage valid: cleared by reset, advances only when enabled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else if (en) begin
        r_valid <= in_valid;
      end
    end

    // Operand data: no reset, so these map onto the DSP input registers.
    always_ff @(posedge clk) begin
      if (en) begin
        r_mode <= in_mode;
        r_a    <= in_a;
        r_b    <= in_b;
        r_m    <= w_s0_m;
        r_q    <= w_s0_q;
        r_u    <= w_s0_u;
        r_l    <= w_s0_l;
      end
    end

    assign w_s1_valid = r_valid;
    assign w_s1_mode  = r_mode;
    assign w_s1_a     = r_a;
    assign w_s1_b     = r_b;
    assign w_s1_m     = r_m;
    assign w_s1_q     = r_q;
    assign w_s1_u     = r_u;
    assign w_s1_l     = r_l;
  end else begin : g_op_bypass
    assign w_s1_valid = in_valid;
    assign w_s1_mode  = in_mode;
    assign w_s1_a     = in_a;
    assign w_s1_b     = in_b;
    assign w_s1_m     = w_s0_m;
    assign w_s1_q     = w_s0_q;
    assign w_s1_u     = w_s0_u;
    assign w_s1_l     = w_s0_l;
  end

  // ---------------------------------------------------------------------
  // Products.
  // ---------------------------------------------------------------------
  logic [FW-1:0] w_p1;
  logic [FW-1:0] w_p2;

  assign w_p1 = FW'(w_s1_a) * FW'(w_s1_b);
  assign w_p2 = FW'(w_s1_m) * FW'(w_s1_q);

  // ---------------------------------------------------------------------
  // Stage 2: product registers (LAT >= 3).
  // ---------------------------------------------------------------------
  logic          w_s2_valid;
  logic [1:0]    w_s2_mode;
  logic [FW-1:0] w_s2_p1;
  logic [FW-1:0] w_s2_p2;
  logic [SW-1:0] w_s2_u;
  logic [SW-1:0] w_s2_l;

  if (LAT >= 3) begin : g_prod_reg
    logic          r_valid;
    logic [1:0]    r_mode;
    logic [FW-1:0] r_p1;
    logic [FW-1:0] r_p2;
    logic [SW-1:0] r_u;
    logic [SW-1:0] r_l;

    // Product-stage valid: cleared by reset, advances only when enabled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else if (en) begin
        r_valid <= w_s1_valid;
      end
    end

    // Product data registers (DSP M registers) and aligned addends.
    always_ff @(posedge clk) begin
      if (en) begin
        r_mode <= w_s1_mode;
        r_p1   <= w_p1;
        r_p2   <= w_p2;
        r_u    <= w_s1_u;
        r_l    <= w_s1_l;
      end
    end

    assign w_s2_valid = r_valid;
    assign w_s2_mode  = r_mode;
    assign w_s2_p1    = r_p1;
    assign w_s2_p2    = r_p2;
    assign w_s2_u     = r_u;
    assign w_s2_l     = r_l;
  end else begin : g_prod_bypass
    assign w_s2_valid = w_s1_valid;
    assign w_s2_mode  = w_s1_mode;
    assign w_s2_p1    = w_p1;
    assign w_s2_p2    = w_p2;
    assign w_s2_u     = w_s1_u;
    assign w_s2_l     = w_s1_l;
  end

  // ---------------------------------------------------------------------
  // Partial sum: second product folded into the post-adder with U and L.
  // ---------------------------------------------------------------------
  logic [FW-1:0] w_base;

  assign w_base = w_s2_p1 + w_s2_p2 + FW'(w_s2_u) + FW'(w_s2_l);

  // ---------------------------------------------------------------------
  // Stage 3: partial-sum register (LAT == 4).
  // ---------------------------------------------------------------------
  logic          w_s3_valid;
  logic [1:0]    w_s3_mode;
  logic [FW-1:0] w_s3_base;

  if (LAT >= 4) begin : g_sum_reg
    logic          r_valid;
    logic [1:0]    r_mode;
    logic [FW-1:0] r_base;

    // Partial-sum valid: cleared by reset, advances only when enabled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else if (en) begin
        r_valid <= w_s2_valid;
      end
    end

    // Partial-sum data register.
    always_ff @(posedge clk) begin
      if (en) begin
        r_mode <= w_s2_mode;
        r_base <= w_base;
      end
    end

    assign w_s3_valid = r_valid;
    assign w_s3_mode  = r_mode;
    assign w_s3_base  = r_base;
  end else begin : g_sum_bypass
    assign w_s3_valid = w_s2_valid;
    assign w_s3_mode  = w_s2_mode;
    assign w_s3_base  = w_base;
  end

  // ---------------------------------------------------------------------
  // Final stage: accumulator term resolved here, immediately before the
  // output register, so ACC always sees the previous emerging result.
  // ---------------------------------------------------------------------
  logic [SW-1:0] r_acc;
  logic [FW-1:0] w_acc_term;
  logic [FW-1:0] w_sum;
  logic [SW-1:0] w_s_next;

  assign w_acc_term = (w_s3_mode == MODE_ACC) ? FW'(r_acc) : '0;
  assign w_sum      = w_s3_base + w_acc_term;
  assign w_s_next   = w_sum[SW-1:0];

  logic          r_out_valid;
  logic [1:0]    r_out_mode;
  logic [SW-1:0] r_out_s;

  // Output registers: valid follows the pipe; data loads only on a valid result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_mode  <= 2'd0;
      r_out_s     <= '0;
    end else if (en) begin
      r_out_valid <= w_s3_valid;
      if (w_s3_valid) begin
        r_out_mode <= w_s3_mode;
        r_out_s    <= w_s_next;
      end
    end
  end

  // Accumulator tracks every emerging result regardless of its mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (en && w_s3_valid) begin
      r_acc <= w_s_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_mode  = r_out_mode;
  assign out_s     = r_out_s;

`ifdef PE_MAC_OVF_FLAG_EN
  logic w_ovf_next;
  logic r_out_ovf;

  assign w_ovf_next = |w_sum[FW-1:SW];

  // Overflow flag, aligned with out_s and held the same way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (en && w_s3_valid) begin
      r_out_ovf <= w_ovf_next;
    end
  end

  assign out_ovf = r_out_ovf;
`endif

endmodule

// File: tb/tb_pe_mac_pipe.sv
// Scoreboard bench for pe_mac_pipe: the driver pushes expected results from
// an arithmetic reference model, a negedge monitor pops and compares them.
// Define PE_MAC_OVF_FLAG_EN to also check out_ovf.

module tb_pe_mac_pipe;

  localparam int unsigned AW    = 17;
  localparam int unsigned BW    = 17;
  localparam int unsigned SW    = 48;
  localparam int unsigned LAT   = 3;
  localparam int unsigned SU_SH = 17;
  localparam int unsigned SL_SH = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          in_valid;
  logic [1:0]    in_mode;
  logic [AW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic [AW-1:0] in_m;
  logic [BW-1:0] in_q;
  logic [SW-1:0] in_sl;
  logic [SW-1:0] in_su;
  logic          out_valid;
  logic [1:0]    out_mode;
  logic [SW-1:0] out_s;
`ifdef PE_MAC_OVF_FLAG_EN
  logic          out_ovf;
`endif

  always #5 clk = ~clk;

  pe_mac_pipe #(
    .AW   (AW),
    .BW   (BW),
    .SW   (SW),
    .LAT  (LAT),
    .SU_SH(SU_SH),
    .SL_SH(SL_SH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_m     (in_m),
    .in_q     (in_q),
    .in_sl    (in_sl),
    .in_su    (in_su),
    .out_valid(out_valid),
    .out_mode (out_mode),
`ifdef PE_MAC_OVF_FLAG_EN
    .out_ovf  (out_ovf),
`endif
    .out_s    (out_s)
  );

  typedef struct packed {
    logic [1:0]    mode;
    logic [SW-1:0] s;
    logic          ovf;
    logic [31:0]   due;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   n_vec   = 0;
  int unsigned   n_err   = 0;
  int unsigned   n_edges = 0;
  bit            en_seen  = 1'b0;
  bit            rst_seen = 1'b0;
  logic [SW-1:0] model_acc = '0;
  logic          prev_valid;
  logic [1:0]    prev_mode;
  logic [SW-1:0] prev_s;
`ifdef PE_MAC_OVF_FLAG_EN
  logic          prev_ovf;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: full-precision sum from the mode rules, then truncation.
  function automatic exp_t model(input logic [1:0] mode, input logic [AW-1:0] a,
                                 input logic [BW-1:0] b, input logic [AW-1:0] m,
                                 input logic [BW-1:0] q, input logic [SW-1:0] sl,
                                 input logic [SW-1:0] su);
    exp_t          e;
    logic [63:0]   full;
    logic [SW-1:0] u;
    logic [SW-1:0] l;
    u = su << SU_SH;
    l = sl << SL_SH;
    case (mode)
      2'd0:    full = 64'(a) * 64'(b);
      2'd1:    full = 64'(a) * 64'(b) + 64'(u);
      2'd2:    full = 64'(a) * 64'(b) + 64'(m) * 64'(q) + 64'(u) + 64'(l);
      default: full = 64'(model_acc) + 64'(a) * 64'(b) + 64'(m) * 64'(q);
    endcase
    e.mode = mode;
    e.s    = full[SW-1:0];
    e.ovf  = ((full >> SW) != 64'd0);
    e.due  = '0;
    return e;
  endfunction

  // One clock of stimulus; accepted transactions go to the scoreboard.
  task automatic step(input bit v_en, input bit v_valid, input logic [1:0] mode,
                      input logic [AW-1:0] a, input logic [BW-1:0] b,
                      input logic [AW-1:0] m, input logic [BW-1:0] q,
                      input logic [SW-1:0] sl, input logic [SW-1:0] su);
    exp_t e;
    rst_n    = 1'b1;
    en       = v_en;
    in_valid = v_valid;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    in_m     = m;
    in_q     = q;
    in_sl    = sl;
    in_su    = su;
    if (v_en && v_valid) begin
      e     = model(mode, a, b, m, q, sl, su);
      e.due = n_edges + LAT;
      exp_q.push_back(e);
      model_acc = e.s;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] rnd_s();
    return SW'({$urandom(), $urandom()});
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)), AW'($urandom()), BW'($urandom()),
           AW'($urandom()), BW'($urandom()), rnd_s(), rnd_s());
    end
  endtask

  // Reset for one edge; results not yet emerged are discarded.
  task automatic pulse_reset();
    while (exp_q.size() > 0 && exp_q[$].due > n_edges) void'(exp_q.pop_back());
    model_acc = '0;
    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'd2;
    @(posedge clk);
    #1;
  endtask

  // Edge bookkeeping: count enabled, non-reset edges.
  initial begin
    forever begin
      @(posedge clk);
      rst_seen = rst_n;
      en_seen  = en && rst_n;
      if (en_seen) n_edges++;
    end
  end

  // Monitor: pop on each new result, check hold while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_seen && !en_seen) begin
        check("hold_valid", 64'(out_valid), 64'(prev_valid));
        check("hold_mode", 64'(out_mode), 64'(prev_mode));
        check("hold_s", 64'(out_s), 64'(prev_s));
`ifdef PE_MAC_OVF_FLAG_EN
        check("hold_ovf", 64'(out_ovf), 64'(prev_ovf));
`endif
      end else if (en_seen && out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got out_s 0x%0h, required no output", out_s);
        end else begin
          e = exp_q.pop_front();
          check("out_s", 64'(out_s), 64'(e.s));
          check("out_mode", 64'(out_mode), 64'(e.mode));
          check("latency_edge", 64'(n_edges), 64'(e.due));
`ifdef PE_MAC_OVF_FLAG_EN
          check("out_ovf", 64'(out_ovf), 64'(e.ovf));
`endif
        end
      end else if (en_seen && exp_q.size() > 0) begin
        check("result_not_overdue", 64'(exp_q[0].due > n_edges), 64'd1);
      end
      prev_valid = out_valid;
      prev_mode  = out_mode;
      prev_s     = out_s;
`ifdef PE_MAC_OVF_FLAG_EN
      prev_ovf   = out_ovf;
`endif
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    in_mode  = 2'd0;
    in_a     = '0;
    in_b     = '0;
    in_m     = '0;
    in_q     = '0;
    in_sl    = '0;
    in_su    = '0;
    // Reset wins over en=0.
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_mode", 64'(out_mode), 64'd0);
    check("reset_s", 64'(out_s), 64'd0);

    // Basic modes.
    step(1, 1, 2'd0, 17'h1FFFF, 17'h1FFFF, 17'h155, 17'h0AA, rnd_s(), rnd_s());
    step(1, 1, 2'd1, 17'h1FFFF, 17'h1FFFF, 17'h1234, 17'h4321, rnd_s(), 48'd1);
    step(1, 1, 2'd2, 17'd3, 17'd5, 17'd7, 17'd11, 48'd9, 48'd2);
    idle(LAT);

    // ACC chain back-to-back: 6, 7, 24.
    step(1, 1, 2'd0, 17'd2, 17'd3, 17'd0, 17'd0, 48'd0, 48'd0);
    step(1, 1, 2'd3, 17'd1, 17'd1, 17'd0, 17'd0, rnd_s(), rnd_s());
    step(1, 1, 2'd3, 17'd4, 17'd4, 17'd1, 17'd1, rnd_s(), rnd_s());
    idle(LAT);

    // Same chain with a 4-cycle stall after the second acceptance.
    step(1, 1, 2'd0, 17'd2, 17'd3, 17'd0, 17'd0, 48'd0, 48'd0);
    step(1, 1, 2'd3, 17'd1, 17'd1, 17'd0, 17'd0, rnd_s(), rnd_s());
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'd0, AW'($urandom()), BW'($urandom()), 17'd0, 17'd0, 48'd0, 48'd0);
    end
    step(1, 1, 2'd3, 17'd4, 17'd4, 17'd1, 17'd1, rnd_s(), rnd_s());
    idle(LAT + 1);

    // Wrap to exactly 2^48, then a clean result.
    step(1, 1, 2'd2, 17'd1, 17'd1, 17'd0, 17'd0, 48'h1FFFF, 48'h7FFFFFFF);
    step(1, 1, 2'd0, 17'd1, 17'd1, 17'd0, 17'd0, 48'd0, 48'd0);
    idle(LAT);

    // Reset mid-flight: in-flight work vanishes, acc restarts at 0.
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd2, AW'($urandom()), BW'($urandom()), AW'($urandom()), BW'($urandom()),
           rnd_s(), rnd_s());
    end
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 2'd2, 17'd0, 17'd0, 17'd0, 17'd0, 48'd0, 48'd0);
      check("post_reset_valid", 64'(out_valid), 64'd0);
      check("post_reset_s", 64'(out_s), 64'd0);
    end
    step(1, 1, 2'd3, 17'd1, 17'd1, 17'd0, 17'd0, rnd_s(), rnd_s());
    idle(LAT);

    // Randomised traffic with stalls, bubbles and corner operands.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic [AW-1:0] m;
      logic [BW-1:0] q;
      a = AW'($urandom());
      b = BW'($urandom());
      m = AW'($urandom());
      q = BW'($urandom());
      if ($urandom_range(0, 7) == 0) begin
        a = '1;
        b = '1;
        m = '1;
        q = '1;
      end
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), a, b, m, q, rnd_s(), rnd_s());
    end
    idle(LAT + 2);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
